tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Run/stop controller for the sample-rate tick of the sine-wave generator. Contains a programmable modulus-N tick counter and sequences it in continuous or fixed-length burst mode. Runtime divider changes are accepted through a valid/ready handshake and applied only on a tick boundary, so no short or long periods are produced. The `tick` output drives the enable of the phase accumulator / LUT readout pipeline.

## Interface
- `DIV_WIDTH`, 32: width of divider and internal counter.
- `CNT_WIDTH`, 16: width of burst length and tick index.
- `DEFAULT_DIV`, 1000: divider after reset (100 kHz tick at 100 MHz clk).

- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: start request; sampled only in IDLE.
- `stop` in 1: abort request; sampled in RUN.
- `mode` in 1: 0 = continuous, 1 = burst; latched at start.
- `burst_len` in CNT_WIDTH: ticks per burst; latched at start.
- `cfg_valid` in 1: new divider offered.
- `cfg_div` in DIV_WIDTH: new divider value.
- `cfg_ready` out 1: pending slot free; transfer when `cfg_valid && cfg_ready`.
- `tick` out 1: single-cycle enable pulse.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at burst completion.
- `tick_idx` out CNT_WIDTH: ticks issued since last start.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> IDLE on `stop`.
  - RUN -> DONE when burst count reached.
  - DONE -> IDLE unconditionally after one cycle.
- Reset (`rst_n`=0 at an edge): state IDLE, counter 0, active divider `DEFAULT_DIV`, no pending config.
  - Outputs after reset: `tick`=0, `busy`=0, `done`=0, `tick_idx`=0, `cfg_ready`=1.
  - Reset mid-burst aborts; no `done`.
- Divider clamping: effective divider = max(div, 1). A divider of 0 or 1 gives a tick every cycle.
- On start:
  - Counter and `tick_idx` are cleared.
  - `mode` and `burst_len` are latched.
- In RUN:
  - Counter increments each cycle.
  - When counter == div-1: counter wraps to 0, `tick` is asserted for one cycle, and `tick_idx` increments (wraps modulo 2^CNT_WIDTH).
- Burst mode:
  - The edge that issues tick number `burst_len` moves to DONE.
  - `burst_len`=0 means start goes straight to DONE with no ticks.
- Continuous mode never leaves RUN except via `stop` or reset.
- Config handshake:
  - An accepted `cfg_div` goes to a pending register and `cfg_ready` drops.
  - In IDLE, the pending value is applied at the next edge.
  - In RUN, the pending value is applied at the wrap edge, and the next period uses it.
  - After apply, `cfg_ready` returns to 1.
  - A transfer on the same edge as a wrap stays pending until the following wrap.
- Priority in RUN: `stop` > wrap/tick > burst completion.
  - `stop` on a wrap edge suppresses that tick.
  - `start` is ignored while `busy` or in DONE.
  - `stop` is ignored in IDLE/DONE.

## Timing
- Edge E0 samples `start` in IDLE. From E0+1, state is RUN and `busy`=1.
- First `tick` is registered at edge E0+div and high for one cycle. Subsequent ticks follow every div cycles exactly.
- Burst completion:
  - Last tick at edge Et: state DONE, `busy`=0, `done`=1 from Et+1 for one cycle; IDLE at Et+2.
  - The last `tick` and `done` are in consecutive cycles, never the same one.
- `stop` sampled at edge Es: `busy`=0 and `tick`=0 from Es+1; counter and `tick_idx` hold until next start.
- Divider change latency in RUN: takes effect at the first wrap edge after acceptance, i.e. within one current period.
- `cfg_ready` is registered; it is low from the edge after acceptance until the edge after apply.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles, release -> all outputs 0 except `cfg_ready`=1; no ticks for 2000 cycles.
- Continuous, div=10: start at E0 -> ticks at E0+10, +20, +30; `tick_idx`=3 after third tick; stop -> no further ticks, `busy`=0.
- Burst, div=4, burst_len=5:
  - Ticks at E0+4..E0+20 step 4; `done` high only at E0+21; `busy` low from E0+21.
  - A start at E0+8 is ignored.
- Runtime reconfig, div=8 to 3 (offered mid-period) -> current period stays 8, next periods 3; `cfg_ready` low until apply.
- Corner cases:
  - div=0 -> tick every cycle.
  - burst_len=0 -> `done` at E0+2, no tick.
  - Stop coincident with wrap edge -> tick suppressed.
- Reset mid-burst (div=5, burst_len=10, `rst_n` low after 3 ticks) -> no `done`; divider back to 1000.

Source files
------------

// File: rtl/tick_scheduler.sv
// Run/stop sequencer for the sample-rate tick: modulus-N counter with continuous
// or fixed-length burst operation and tick-aligned divider reconfiguration.
module tick_scheduler #(
  parameter int unsigned DIV_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mode,
  input  logic [CNT_WIDTH-1:0] burst_len,
  input  logic                 cfg_valid,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic                 cfg_ready,
  output logic                 tick,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] tick_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] div_act, div_act_n;
  logic [DIV_WIDTH-1:0] div_pend, div_pend_n;
  logic [DIV_WIDTH-1:0] div_eff;
  logic                 pend, pend_n;
  logic                 mode_q, mode_n;
  logic [CNT_WIDTH-1:0] blen_q, blen_n;
  logic [CNT_WIDTH-1:0] idx_n;
  logic                 tick_n, busy_n, done_n;
  logic                 wrap, xfer;

  // A divider of 0 behaves like 1: one tick per cycle.
  assign div_eff = (div_act == '0) ? DIV_WIDTH'(1) : div_act;
  assign wrap    = (cnt == div_eff - DIV_WIDTH'(1));
  assign xfer    = cfg_valid && cfg_ready;

  // State and datapath register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      div_act   <= DIV_WIDTH'(DEFAULT_DIV);
      div_pend  <= '0;
      pend      <= 1'b0;
      mode_q    <= 1'b0;
      blen_q    <= '0;
      tick_idx  <= '0;
      tick      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      div_act   <= div_act_n;
      div_pend  <= div_pend_n;
      pend      <= pend_n;
      mode_q    <= mode_n;
      blen_q    <= blen_n;
      tick_idx  <= idx_n;
      tick      <= tick_n;
      busy      <= busy_n;
      done      <= done_n;
      cfg_ready <= !pend_n;
    end
  end

  // Next-state, counter, config and output logic.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    div_act_n  = div_act;
    div_pend_n = div_pend;
    pend_n     = pend;
    mode_n     = mode_q;
    blen_n     = blen_q;
    idx_n      = tick_idx;
    tick_n     = 1'b0;
    done_n     = 1'b0;

    // Pending divider lands immediately when stopped, otherwise only on a wrap.
    if (pend && (state != S_RUN || wrap)) begin
      div_act_n = div_pend;
      pend_n    = 1'b0;
    end
    if (xfer) begin
      div_pend_n = cfg_div;
      pend_n     = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          cnt_n   = '0;
          idx_n   = '0;
          mode_n  = mode;
          blen_n  = burst_len;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_n = S_IDLE;
        end else if (mode_q && blen_q == '0) begin
          state_n = S_DONE;
        end else begin
          cnt_n = wrap ? '0 : cnt + DIV_WIDTH'(1);
          if (wrap) begin
            tick_n = 1'b1;
            idx_n  = tick_idx + CNT_WIDTH'(1);
            if (mode_q && idx_n == blen_q) state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // busy covers the final tick cycle so it never overlaps done.
    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: expected tick/done edges are queued by the
// stimulus thread and matched by a monitor whenever the DUT pulses an output.
module tb_tick_scheduler;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, mode, cfg_valid;
  logic [CW-1:0] burst_len;
  logic [DW-1:0] cfg_div;
  logic          cfg_ready, tick, busy, done;
  logic [CW-1:0] tick_idx;

  tick_scheduler #(.DIV_WIDTH(DW), .CNT_WIDTH(CW), .DEFAULT_DIV(1000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .burst_len(burst_len), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .tick(tick), .busy(busy), .done(done), .tick_idx(tick_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tq[$];
  int dq[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every tick/done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      if (tq.size() > 0) chk("tick_edge", cyc, tq.pop_front());
      else begin
        total_cnt++;
        $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
      end
    end
    if (done === 1'b1) begin
      if (dq.size() > 0) chk("done_edge", cyc, dq.pop_front());
      else begin
        total_cnt++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_div(input logic [DW-1:0] v);
    cfg_valid = 1'b1;
    cfg_div   = v;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_ready_pending", cfg_ready, 0);
    @(negedge clk);
    chk("cfg_ready_applied", cfg_ready, 1);
  endtask

  task automatic start_pulse(input logic m, input logic [CW-1:0] bl);
    start     = 1'b1;
    mode      = m;
    burst_len = bl;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic drain(input string name);
    chk({name, "_ticks_left"}, tq.size(), 0);
    chk({name, "_dones_left"}, dq.size(), 0);
    tq.delete();
    dq.delete();
  endtask

  int e0;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    burst_len = '0; cfg_valid = 1'b0; cfg_div = '0;

    // Reset and idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", tick_idx, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    repeat (2000) @(negedge clk);
    drain("idle");

    // Continuous, div=10
    set_div(DW'(10));
    e0 = cyc + 1;
    tq.push_back(e0 + 10); tq.push_back(e0 + 20); tq.push_back(e0 + 30);
    start_pulse(1'b0, CW'(0));
    chk("cont_busy", busy, 1);
    wait_until(e0 + 30);
    chk("cont_idx3", tick_idx, 3);
    wait_until(e0 + 32);
    stop_pulse();
    chk("cont_stop_busy", busy, 0);
    repeat (30) @(negedge clk);
    chk("cont_idx_hold", tick_idx, 3);
    drain("cont");

    // Burst, div=4, len=5, with an ignored start mid-burst
    set_div(DW'(4));
    e0 = cyc + 1;
    for (int k = 1; k <= 5; k++) tq.push_back(e0 + 4 * k);
    dq.push_back(e0 + 21);
    start_pulse(1'b1, CW'(5));
    wait_until(e0 + 7);
    start_pulse(1'b1, CW'(5));
    wait_until(e0 + 20);
    chk("burst_busy_last", busy, 1);
    wait_until(e0 + 21);
    chk("burst_busy_off", busy, 0);
    chk("burst_idx", tick_idx, 5);
    wait_until(e0 + 40);
    drain("burst");

    // Runtime reconfig 8 -> 3 offered mid-period
    set_div(DW'(8));
    e0 = cyc + 1;
    tq.push_back(e0 + 8); tq.push_back(e0 + 11);
    tq.push_back(e0 + 14); tq.push_back(e0 + 17);
    start_pulse(1'b0, CW'(0));
    wait_until(e0 + 2);
    cfg_valid = 1'b1;
    cfg_div   = DW'(3);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("reconf_ready_low", cfg_ready, 0);
    wait_until(e0 + 7);
    chk("reconf_ready_still_low", cfg_ready, 0);
    wait_until(e0 + 8);
    chk("reconf_ready_high", cfg_ready, 1);
    wait_until(e0 + 18);
    stop_pulse();
    chk("reconf_idx", tick_idx, 4);
    repeat (10) @(negedge clk);
    drain("reconf");

    // Stop on a wrap edge suppresses that tick (div=3 still active)
    e0 = cyc + 1;
    tq.push_back(e0 + 3); tq.push_back(e0 + 6);
    start_pulse(1'b0, CW'(0));
    wait_until(e0 + 8);
    stop_pulse();
    chk("stopwrap_tick", tick, 0);
    chk("stopwrap_busy", busy, 0);
    chk("stopwrap_idx", tick_idx, 2);
    repeat (10) @(negedge clk);
    drain("stopwrap");

    // div=0 ticks every cycle
    set_div(DW'(0));
    e0 = cyc + 1;
    for (int k = 1; k <= 5; k++) tq.push_back(e0 + k);
    start_pulse(1'b0, CW'(0));
    wait_until(e0 + 5);
    stop_pulse();
    chk("div0_busy", busy, 0);
    chk("div0_idx", tick_idx, 5);
    repeat (10) @(negedge clk);
    drain("div0");

    // burst_len=0: done two edges after start, no tick
    e0 = cyc + 1;
    dq.push_back(e0 + 2);
    start_pulse(1'b1, CW'(0));
    wait_until(e0 + 1);
    chk("blen0_busy", busy, 1);
    wait_until(e0 + 2);
    chk("blen0_busy_off", busy, 0);
    repeat (10) @(negedge clk);
    drain("blen0");

    // Reset mid-burst: no done, divider returns to 1000
    set_div(DW'(5));
    e0 = cyc + 1;
    tq.push_back(e0 + 5); tq.push_back(e0 + 10); tq.push_back(e0 + 15);
    start_pulse(1'b1, CW'(10));
    wait_until(e0 + 16);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_idx", tick_idx, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    e0 = cyc + 1;
    tq.push_back(e0 + 1000);
    start_pulse(1'b0, CW'(0));
    wait_until(e0 + 1000);
    stop_pulse();
    chk("defdiv_idx", tick_idx, 1);
    repeat (20) @(negedge clk);
    drain("midrst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
